disp7segs_barrido: RTL and testbench
====================================

Name: disp7segs_barrido

Overview:
- Time-multiplexed scan controller for an N-digit common-anode 7-segment bank that shares one hex-to-segment decoder.
- Accepts a packed hex word via a valid/ready handshake and holds it in a shadow register.
- Commits the word only at frame boundaries, so no digit shows a partial update.
- Sequences digit enables with a dead-time blank per slot to suppress ghosting; sits between the CPU/debug datapath and the board display pins.

Parameters:
- N_DIG, 4, number of digits scanned (1..8).
- DIV, 50000, clock cycles per digit slot (≥2).
- BLANK, 500, cycles at the start of each slot with all anodes off (0 ≤ BLANK < DIV).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- dato_i  in  4*N_DIG  packed hex nibbles; digit k = dato_i[4k+3:4k]; digit 0 is rightmost.
- valido_i  in  1  dato_i valid this cycle.
- listo_o  out  1  block can accept dato_i.
- segmentos_o  out  7  segment drive, active-low, {g,f,e,d,c,b,a}.
- anodos_o  out  N_DIG  digit enable, active-low, one-hot-cold or all ones.
- digito_o  out  clog2(N_DIG) (min 1)  index of the digit currently in its slot.

Behaviour:
- Single clock (clk_i). Synchronous active-high reset (rst_i). Every register is updated only on the rising edge of clk_i.
- Reset values:
  - slot counter = 0, digit index = 0, pending flag = 0.
  - display and pending registers = 0.
  - anodos_o = all 1, segmentos_o = 7'b1111111, digito_o = 0, listo_o = 1.
- Slot counter: width clog2(DIV). Counts 0..DIV-1, then wraps to 0. On wrap, the index goes to (index+1) mod N_DIG.
- Frame end: the cycle where count = DIV-1 and index = N_DIG-1.
- Slot phases, held as 2 states:
  - APAGADO while count < BLANK; all anodes off.
  - ENCENDIDO otherwise; only anodos_o[index] = 0.
  - With BLANK = 0, the block is always ENCENDIDO.
- segmentos_o:
  - Registered decode of display nibble [index] during ENCENDIDO.
  - 7'b1111111 during APAGADO.
- Output latency: outputs are registered. anodos_o, segmentos_o and digito_o at cycle t+1 reflect counter/index state at cycle t. All three outputs are aligned, so they never mismatch by a cycle.
- Handshake:
  - Transfer occurs when valido_i && listo_o. dato_i is then captured into pending, pending flag sets, and listo_o drops on the next cycle.
  - valido_i while listo_o = 0 is ignored; the pending data is not overwritten.
  - At frame end with pending flag = 1: pending is copied to display, the flag clears, and listo_o = 1 on the next cycle.
  - The new word first appears in digit 0's slot of the following frame.
- Simultaneous transfer and frame end (flag previously 0): capture only. The commit waits for the next frame end, so a word is never captured and committed in the same cycle.
- Reset mid-frame: all state returns to reset values the next cycle. Pending data is discarded.
- Decode table, 0..F: standard hex glyphs, active-low.
  - 0 = 1000000, 1 = 1111001, 7 = 1111000, 8 = 0000000.
  - A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.

Optional Feature:
- Macro: DISP_CEROS_IZQ_EN (leading-zero blanking).
- Defined: scanning from digit N_DIG-1 downward, each zero nibble above the most significant nonzero nibble outputs 7'b1111111 in its slot. Its anode still pulses, so timing is unchanged. Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: all digits are always decoded.

Decomposition:
- Shared package disp_pkg:
  - SEG_APAGADO = 7'b1111111.
  - The 16-entry segment constant table.
  - State typedef {APAGADO, ENCENDIDO}.
- One sub-module, decodificador_hex_7seg: a combinational nibble-to-segment function built from the package table. It is instantiated once and fed by the index mux.
- Scanning, handshake and registers stay in the top module.

Test Plan (N_DIG=4, DIV=8, BLANK=2):
- Reset, then 40 cycles idle -> anodos_o cycles 1110, 1101, 1011, 0111. Each digit is low 6 of 8 cycles, with 2 all-ones cycles per slot; segmentos_o = 1000000 while lit; listo_o = 1 throughout.
- Send dato_i = 16'h12AF with valido_i for 1 cycle mid-frame -> listo_o low from the next cycle until 1 cycle after frame end. The next frame shows digit 0 = 0001110 (F), digit 1 = 0001000 (A), digit 2 = 0100100 (2), digit 3 = 1111001 (1).
- While listo_o = 0, pulse valido_i with 16'hFFFF -> ignored; display shows 16'h12AF after commit.
- Assert valido_i with 16'h0007 exactly on the frame-end cycle -> captured, not committed. It commits at the next frame end (32 cycles later); digit 0 shows 1111000.
- Assert rst_i at count 5 of digit 2 -> next cycle anodos_o = 1111, segmentos_o = 1111111, digito_o = 0, listo_o = 1, display = 0.
- With DISP_CEROS_IZQ_EN, dato_i = 16'h0040 -> digits 3 and 2 show 1111111, digit 1 shows 0011001, digit 0 shows 1000000.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment scan controller: active-low hex glyph table,
// blank pattern and the two slot phases.
package disp_pkg;

    localparam logic [6:0] SEG_APAGADO = 7'b1111111;

    // {g,f,e,d,c,b,a}, active-low, indexed by nibble value
    localparam logic [6:0] TABLA_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {
        APAGADO,
        ENCENDIDO
    } estado_t;

    function automatic logic [6:0] seg_de_nibble(input logic [3:0] nib);
        return TABLA_SEG[nib];
    endfunction

endpackage

// File: rtl/disp7segs_barrido_decodificador.sv
// Combinational nibble-to-segment decoder shared by every digit of the scan bank.
module decodificador_hex_7seg
    import disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segmentos
);

    assign o_segmentos = seg_de_nibble(i_nibble);

endmodule

// File: rtl/disp7segs_barrido.sv
// Time-multiplexed N-digit 7-segment scanner with per-slot dead-time and frame-aligned commit.
// Optional leading-zero blanking when DISP_CEROS_IZQ_EN is defined.
module disp7segs_barrido
    import disp_pkg::*;
#(
    parameter int N_DIG = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [4*N_DIG-1:0]                    dato_i,
    input  logic                                  valido_i,
    output logic                                  listo_o,
    output logic [6:0]                            segmentos_o,
    output logic [N_DIG-1:0]                      anodos_o,
    output logic [((N_DIG > 1) ? $clog2(N_DIG) : 1)-1:0] digito_o
);

    localparam int W_CNT = $clog2(DIV);
    localparam int W_IDX = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(DIV - 1);
    localparam logic [W_IDX-1:0] IDX_MAX = W_IDX'(N_DIG - 1);

    logic [W_CNT-1:0]   r_cnt;
    logic [W_IDX-1:0]   r_idx;
    logic               r_flag;
    logic [4*N_DIG-1:0] r_pend;
    logic [4*N_DIG-1:0] r_disp;
    logic [N_DIG-1:0]   r_anodos;
    logic [6:0]         r_seg;
    logic [W_IDX-1:0]   r_dig;

    logic               w_fin_slot;
    logic               w_fin_marco;
    estado_t            w_estado;
    logic [3:0]         w_nib;
    logic [6:0]         w_seg_dec;
    logic [N_DIG-1:0]   w_ocultar_v;
    logic               w_ocultar;
    logic [N_DIG-1:0]   w_anodos_on;

    assign w_fin_slot  = (r_cnt == CNT_MAX);
    assign w_fin_marco = w_fin_slot && (r_idx == IDX_MAX);

    generate
        if (BLANK == 0) begin : g_sin_blank
            assign w_estado = ENCENDIDO;
        end else begin : g_blank
            localparam logic [W_CNT-1:0] CNT_BLANK = W_CNT'(BLANK);
            assign w_estado = (r_cnt < CNT_BLANK) ? APAGADO : ENCENDIDO;
        end
    endgenerate

    assign w_nib       = 4'(r_disp >> {r_idx, 2'b00});
    assign w_anodos_on = ~(N_DIG'(1) << r_idx);

    decodificador_hex_7seg u_dec (
        .i_nibble    (w_nib),
        .o_segmentos (w_seg_dec)
    );

    // A digit is hidden only while every nibble from it up to the MSD is zero; digit 0 never.
`ifdef DISP_CEROS_IZQ_EN
    logic w_ceros;
    always_comb begin
        w_ocultar_v = '0;
        w_ceros     = 1'b1;
        for (int k = N_DIG - 1; k >= 1; k--) begin
            w_ceros        = w_ceros && (r_disp[4*k +: 4] == 4'h0);
            w_ocultar_v[k] = w_ceros;
        end
    end
`else
    always_comb begin
        w_ocultar_v = '0;
    end
`endif

    assign w_ocultar = w_ocultar_v[r_idx];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_flag   <= 1'b0;
            r_pend   <= '0;
            r_disp   <= '0;
            r_anodos <= '1;
            r_seg    <= SEG_APAGADO;
            r_dig    <= '0;
        end else begin
            r_cnt <= w_fin_slot ? '0 : r_cnt + W_CNT'(1);
            if (w_fin_slot) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + W_IDX'(1);
            end

            // Commit and capture are exclusive on r_flag, so a word never does both in one cycle.
            if (w_fin_marco && r_flag) begin
                r_disp <= r_pend;
                r_flag <= 1'b0;
            end else if (valido_i && !r_flag) begin
                r_pend <= dato_i;
                r_flag <= 1'b1;
            end

            r_dig <= r_idx;
            if (w_estado == APAGADO) begin
                r_anodos <= '1;
                r_seg    <= SEG_APAGADO;
            end else begin
                r_anodos <= w_anodos_on;
                r_seg    <= w_ocultar ? SEG_APAGADO : w_seg_dec;
            end
        end
    end

    assign listo_o     = ~r_flag;
    assign segmentos_o = r_seg;
    assign anodos_o    = r_anodos;
    assign digito_o    = r_dig;

endmodule

// File: tb/tb_disp7segs_barrido.sv
// Self-checking bench for disp7segs_barrido (N_DIG=4, DIV=8, BLANK=2) against a
// cycle-time behavioural model; honours DISP_CEROS_IZQ_EN for leading-zero blanking.
module tb_disp7segs_barrido;

    localparam int N_DIG = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    localparam logic [6:0] GLIFO [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valido = 1'b0;
    logic [15:0] dato = '0;
    logic        listo;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  dig;

    int checks = 0;
    int errors = 0;

    disp7segs_barrido #(.N_DIG(N_DIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .dato_i      (dato),
        .valido_i    (valido),
        .listo_o     (listo),
        .segmentos_o (seg),
        .anodos_o    (an),
        .digito_o    (dig)
    );

    always #5 clk = ~clk;

    // Model: elapsed cycles since reset define the slot position directly.
    int          m_t = 0;
    bit          m_flag = 0;
    bit          m_ok = 0;
    logic [15:0] m_pend = '0;
    logic [15:0] m_disp = '0;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic [1:0]  e_dig;

    function automatic logic [6:0] glifo_esperado(input logic [15:0] v, input int k);
        logic [3:0] nib;
        nib = 4'((v >> (4 * k)) & 16'hF);
`ifdef DISP_CEROS_IZQ_EN
        begin
            int msnz;
            msnz = 0;
            for (int j = 0; j < N_DIG; j++)
                if (((v >> (4 * j)) & 16'hF) != 0) msnz = j;
            if (k > msnz) return 7'b1111111;
        end
`endif
        return GLIFO[nib];
    endfunction

    always @(posedge clk) begin
        int cnt;
        int idx;
        if (rst) begin
            m_t = 0; m_flag = 0; m_pend = '0; m_disp = '0;
            e_an = 4'hF; e_seg = 7'h7F; e_dig = 2'd0;
            m_ok = 1;
        end else begin
            cnt = m_t % DIV;
            idx = (m_t / DIV) % N_DIG;
            e_dig = 2'(idx);
            if (cnt < BLANK) begin
                e_an = 4'hF; e_seg = 7'h7F;
            end else begin
                e_an = ~(4'b0001 << idx);
                e_seg = glifo_esperado(m_disp, idx);
            end
            if (cnt == DIV - 1 && idx == N_DIG - 1 && m_flag) begin
                m_disp = m_pend; m_flag = 0;
            end else if (valido && !m_flag) begin
                m_pend = dato; m_flag = 1;
            end
            m_t = (m_t + 1) % (DIV * N_DIG);
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_anodos", 32'(an), 32'(e_an));
            chk("model_segmentos", 32'(seg), 32'(e_seg));
            chk("model_digito", 32'(dig), 32'(e_dig));
            chk("model_listo", 32'(listo), 32'(!m_flag));
        end
    end

    // Returns at the negedge before the edge on which the slot position is (idx,cnt).
    task automatic esperar(input int idx, input int cnt);
        int n;
        n = 0;
        while (!((m_t % DIV) == cnt && ((m_t / DIV) % N_DIG) == idx) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL timeout waiting for slot %0d count %0d", idx, cnt);
        end
    endtask

    task automatic ver_digito(input int idx, input logic [6:0] s, input logic [3:0] a);
        esperar(idx, BLANK + 1);
        @(negedge clk);
        chk($sformatf("lit_seg_d%0d", idx), 32'(seg), 32'(s));
        chk($sformatf("lit_an_d%0d", idx), 32'(an), 32'(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_anodos", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dig", 32'(dig), 32'h0);
        chk("rst_listo", 32'(listo), 32'h1);
        rst = 1'b0;

        repeat (40) @(negedge clk);
        ver_digito(2, 7'b1000000, 4'b1011);
        ver_digito(0, 7'b1000000, 4'b1110);
        esperar(3, 1);
        @(negedge clk);
        chk("lit_blank_an", 32'(an), 32'hF);

        // Word mid-frame, then an ignored write while busy
        esperar(1, 3);
        dato = 16'h12AF; valido = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        chk("lit_listo_baja", 32'(listo), 32'h0);
        repeat (3) @(negedge clk);
        dato = 16'hFFFF; valido = 1'b1;
        @(negedge clk);
        valido = 1'b0; dato = '0;
        esperar(3, 7);
        chk("lit_listo_fe", 32'(listo), 32'h0);
        @(negedge clk);
        chk("lit_listo_sube", 32'(listo), 32'h1);
        ver_digito(0, 7'b0001110, 4'b1110);
        ver_digito(1, 7'b0001000, 4'b1101);
        ver_digito(2, 7'b0100100, 4'b1011);
        ver_digito(3, 7'b1111001, 4'b0111);

        // Capture exactly on frame end: commit waits a whole frame
        esperar(3, 7);
        dato = 16'h0007; valido = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        chk("lit_listo_fe_cap", 32'(listo), 32'h0);
        ver_digito(0, 7'b0001110, 4'b1110);
        ver_digito(0, 7'b1111000, 4'b1110);

        // Reset at count 5 of digit 2
        esperar(2, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        chk("midrst_dig", 32'(dig), 32'h0);
        chk("midrst_listo", 32'(listo), 32'h1);
        rst = 1'b0;
        ver_digito(0, 7'b1000000, 4'b1110);

        esperar(0, 2);
        dato = 16'h0040; valido = 1'b1;
        @(negedge clk);
        valido = 1'b0;
        esperar(3, 7);
        @(negedge clk);
`ifdef DISP_CEROS_IZQ_EN
        ver_digito(0, 7'b1000000, 4'b1110);
        ver_digito(1, 7'b0011001, 4'b1101);
        ver_digito(2, 7'b1111111, 4'b1011);
        ver_digito(3, 7'b1111111, 4'b0111);
`else
        ver_digito(0, 7'b1000000, 4'b1110);
        ver_digito(1, 7'b0011001, 4'b1101);
        ver_digito(2, 7'b1000000, 4'b1011);
        ver_digito(3, 7'b1000000, 4'b0111);
`endif

        // Random traffic, sparse nibbles to exercise zero patterns, rare resets
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            valido = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < N_DIG; k++)
                dato[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            rst = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        rst = 1'b0; valido = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
